// File: rtl/seg7_scan_driver_if.sv
// Bundle between datapath logic and the 7-segment scan driver: value/control
// inputs flow towards the driver, segment/digit pins and frame_tick flow back.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_suppress;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_tick;

    modport master (
        output value, dp_in, digit_en, lz_suppress, load,
        input  seg, dp, dig_sel, frame_tick
    );

    modport slave (
        input  value, dp_in, digit_en, lz_suppress, load,
        output seg, dp, dig_sel, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with a double-buffered value,
// leading-zero suppression, per-digit enables and a blanking dead time per slot.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               reset,
    seg7_scan_driver_if.slave  bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    // Font table is stored low-true; polarity is applied at the output stage.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         pend_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_valid;
    logic [VW-1:0]         disp_val;
    logic [NUM_DIGITS-1:0] disp_dp;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] dig_q;
    logic                  tick_q;

    logic                  presc_wrap;
    logic                  last_digit;
    logic                  frame_end;
    logic                  in_blank;
    logic [3:0]            cur_nib;
    logic [6:0]            seg_pat;
    logic                  dp_lit;
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;
    logic                  digit_off;

    assign presc_wrap = (presc == PW'(REFRESH_DIV - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));
    assign frame_end  = presc_wrap && last_digit;
    assign in_blank   = (presc < PW'(BLANK_CYCLES));
    assign cur_nib    = disp_val[4*idx +: 4];
    assign seg_pat    = (SEG_ACTIVE_LOW != 0) ? hex_to_seg(cur_nib) : ~hex_to_seg(cur_nib);
    assign dp_lit     = (SEG_ACTIVE_LOW != 0) ? ~disp_dp[idx] : disp_dp[idx];
    assign onehot     = NUM_DIGITS'(1) << idx;

    // lead_zero[i] is set when digit i and every more-significant digit are zero.
    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (disp_val[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_run;
        end
    end

    assign digit_off = !bus.digit_en[idx]
                     || (bus.lz_suppress && (idx != '0) && lead_zero[idx]);

    // Scan timing, double buffering and the registered pin stage share one clocked block;
    // a load in the frame-boundary cycle overrides the pending_valid clear below it.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
            dig_q      <= DIG_OFF;
            tick_q     <= 1'b0;
        end else begin
            tick_q <= frame_end;

            if (presc_wrap) begin
                presc <= '0;
                idx   <= last_digit ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            if (frame_end && pend_valid) begin
                disp_val   <= pend_val;
                disp_dp    <= pend_dp;
                pend_valid <= 1'b0;
            end

            if (bus.load) begin
                pend_val   <= bus.value;
                pend_dp    <= bus.dp_in;
                pend_valid <= 1'b1;
            end

            if (in_blank) begin
                seg_q <= SEG_OFF;
                dp_q  <= DP_OFF;
                dig_q <= DIG_OFF;
            end else begin
                dig_q <= (DIG_ACTIVE_LOW != 0) ? ~onehot : onehot;
                seg_q <= digit_off ? SEG_OFF : seg_pat;
                dp_q  <= digit_off ? DP_OFF : dp_lit;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.dig_sel    = dig_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
- Hex-decodes a packed N-nibble value, one digit per scan slot, with:
  - per-digit decimal points;
  - leading-zero suppression;
  - per-digit enable mask;
  - anti-ghosting dead time.
- Double-buffers the displayed value so updates take effect only at frame boundaries (no tearing).
- Sits between counters/datapath logic and the board's shared segment bus plus digit-select lines.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 2, cycles at the start of each slot with all digit selects inactive.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs low-true, 0 = high-true.
- DIG_ACTIVE_LOW, 1, 1 = digit-select outputs low-true.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  packed hex nibbles; digit 0 = bits [3:0].
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- digit_en  in  NUM_DIGITS  1 = digit may light; 0 = forced blank.
- lz_suppress  in  1  1 = blank leading zeros.
- load  in  1  single-cycle strobe; captures value/dp_in into pending buffer.
- seg  out  7  segments {g,f,e,d,c,b,a}, bit 6 = g.
- dp  out  1  decimal point segment.
- dig_sel  out  NUM_DIGITS  one-hot digit select (polarity per DIG_ACTIVE_LOW).
- frame_tick  out  1  one-cycle pulse when the display buffer is refreshed (frame boundary).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset state:
  - prescaler, digit index, pending and display buffers all cleared to 0; pending_valid = 0.
  - seg and dp inactive (all 1 if SEG_ACTIVE_LOW).
  - dig_sel all inactive.
  - frame_tick = 0.
- Reset mid-scan: takes effect at the next edge and discards any pending load.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit index increments.
  - Index wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle in which the prescaler wraps with index = NUM_DIGITS-1.
  - If pending_valid = 1: display buffer <= pending buffer, pending_valid <= 0.
  - frame_tick pulses every frame boundary, whether or not a transfer occurred.
- Load:
  - load = 1 writes value/dp_in into the pending buffer and sets pending_valid.
  - Back-to-back loads overwrite; the last one before the boundary wins.
  - Load coincident with the frame boundary: the transfer uses the pending contents from before this cycle; the new data stays pending with pending_valid = 1 for the next frame.
  - digit_en and lz_suppress are live (not buffered).
- Dead time: while prescaler < BLANK_CYCLES, dig_sel is all inactive and seg/dp are inactive.
- Lit slot: for the remainder of the slot, the dig_sel bit at the current index is active.
- Decode: the nibble drives seg with this active-low pattern, inverted when SEG_ACTIVE_LOW = 0.
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000
  - A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110
- Digit blanked (seg and dp inactive, dig_sel still cycles) if either condition holds:
  - digit_en[i] = 0;
  - lz_suppress = 1 AND i > 0 AND nibbles i..NUM_DIGITS-1 of the display buffer are all zero.
- Digit 0 is never suppressed by the leading-zero rule. A zero value with suppression enabled therefore shows "0".
- dp: dp = dp_buf[i] when digit i is not blanked.
- Output timing: seg, dp and dig_sel are registered and reflect prescaler/index state with exactly 1 cycle latency. Outputs are glitch-free (no combinational paths to pins).

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, active-low):
- Reset held 3 cycles, then released:
  - during reset: seg = 7'h7F, dp = 1, dig_sel = 4'hF;
  - after release, the first lit slot is digit 0 with dig_sel = 4'hE, starting 2 cycles after release.
- load value = 16'h12AF, lz_suppress = 0, digit_en = 4'hF:
  - nothing changes before the next frame_tick;
  - from the next frame, digits 0..3 show seg = 0001110, 0001000, 0100100, 1111001;
  - each slot has 1 dead cycle then 3 lit cycles.
- value = 16'h0050, lz_suppress = 1 -> digits 3 and 2 fully blank, digit 1 = 0010010, digit 0 = 1000000.
- value = 16'h0000, lz_suppress = 1 -> only digit 0 lit, showing 1000000.
- dp_in = 4'b0100, digit_en = 4'b1011 -> dp = 0 only on digit 2 if that digit is enabled; digit 2 is disabled, so dp stays 1 and seg = 7'h7F during slot 2.
- Loads in sequence:
  - load 16'h1111, then 16'h2222 two cycles later, then 16'h3333 exactly on the frame-boundary cycle;
  - the next frame shows 2222 and the following frame shows 3333;
  - assert reset mid-slot -> outputs go inactive the next cycle and pending 3333 is discarded.
